// File: rtl/code_entry_if.sv
// Keypad-to-lock bundle: raw key inputs and clear/secret from the lock FSM, plus entry results back to it.
interface code_entry_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  key_valid;
  logic [3:0]            key_code;
  logic                  clear;
  logic [4*DIGITS-1:0]   secret;
  logic                  digit_strobe;
  logic [3:0]            digit_count;
  logic                  entry_done;
  logic                  code_match;
  logic                  timeout;

  modport slave (
    input  key_valid, key_code, clear, secret,
    output digit_strobe, digit_count, entry_done, code_match, timeout
  );

  modport master (
    output key_valid, key_code, clear, secret,
    input  digit_strobe, digit_count, entry_done, code_match, timeout
  );
endinterface

// File: rtl/code_entry.sv
// Keypad front end: debounces raw presses, collects DIGITS decimal digits and
// compares the completed entry with the stored secret; abandons stale partial entries.
module code_entry #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  code_entry_if.slave bus
);
  localparam int unsigned BUF_W  = 4 * DIGITS;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]  KEY_CANCEL = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_HELD,
    ST_RELEASE
  } db_state_e;

  db_state_e          state_q, state_d;
  logic [3:0]         key_q, key_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               accept_c;

  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [3:0]         count_q, count_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               pend_q, pend_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;
  logic               match_q, match_d;
  logic               timeout_q, timeout_d;
  logic               is_digit_c;
  logic               is_cancel_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      db_cnt_q  <= '0;
      buf_q     <= '0;
      count_q   <= '0;
      idle_q    <= '0;
      pend_q    <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      db_cnt_q  <= db_cnt_d;
      buf_q     <= buf_d;
      count_q   <= count_d;
      idle_q    <= idle_d;
      pend_q    <= pend_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
    end
  end

  // Debounce: a key is accepted once, on the Nth consecutive stable high sample.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    db_cnt_d = db_cnt_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.key_valid) begin
          key_d    = bus.key_code;
          db_cnt_d = DB_W'(1);
          if (DEBOUNCE_CYCLES == 1) begin
            state_d  = ST_HELD;
            accept_c = 1'b1;
          end else begin
            state_d = ST_PRESS;
          end
        end
      end
      ST_PRESS: begin
        if (!bus.key_valid) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (bus.key_code != key_q) begin
          key_d    = bus.key_code;
          db_cnt_d = DB_W'(1);
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
          if (32'(db_cnt_q) + 32'd1 >= DEBOUNCE_CYCLES) begin
            state_d  = ST_HELD;
            accept_c = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (!bus.key_valid) begin
          db_cnt_d = DB_W'(1);
          state_d  = (DEBOUNCE_CYCLES == 1) ? ST_IDLE : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (bus.key_valid) begin
          state_d  = ST_HELD;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
          if (32'(db_cnt_q) + 32'd1 >= DEBOUNCE_CYCLES) begin
            state_d  = ST_IDLE;
            db_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  assign is_digit_c  = accept_c && (key_d <= 4'd9);
  assign is_cancel_c = accept_c && (key_d == KEY_CANCEL);

  // Entry buffer: the final digit is held one cycle (pend) so the count never reads DIGITS.
  always_comb begin
    buf_d     = buf_q;
    count_d   = count_q;
    idle_d    = idle_q;
    pend_d    = 1'b0;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    match_d   = 1'b0;
    timeout_d = 1'b0;
    if (bus.clear) begin
      buf_d   = '0;
      count_d = '0;
      idle_d  = '0;
    end else if (pend_q) begin
      done_d  = 1'b1;
      match_d = (buf_q == bus.secret);
      buf_d   = '0;
      count_d = '0;
      idle_d  = '0;
    end else if (is_digit_c) begin
      strobe_d = 1'b1;
      buf_d    = {buf_q[BUF_W-5:0], key_d};
      idle_d   = '0;
      if (32'(count_q) + 32'd1 == DIGITS) begin
        pend_d = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end else if (is_cancel_c) begin
      buf_d   = '0;
      count_d = '0;
      idle_d  = '0;
    end else if (count_q != 4'd0) begin
      if (32'(idle_q) + 32'd1 >= TIMEOUT_CYCLES) begin
        timeout_d = 1'b1;
        buf_d     = '0;
        count_d   = '0;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
  end

  assign bus.digit_strobe = strobe_q;
  assign bus.digit_count  = count_q;
  assign bus.entry_done   = done_q;
  assign bus.code_match   = match_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_code_entry.sv
// Testbench for code_entry: directed keypad scenarios plus randomized clean presses
// checked against a digit-queue model of the entry rules.
module tb_code_entry;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned DB     = 4;
  localparam int unsigned TO     = 20;
  localparam int          MAXC   = 4096;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_strobe = 0, n_done = 0, n_to = 0;
  int   last_strobe_cyc = -1, last_done_cyc = -1, last_to_cyc = -1;
  logic last_match = 1'b0;

  logic kv_a   [MAXC];
  int   kc_a   [MAXC];
  int   acc_a  [MAXC];
  bit   e_str  [MAXC];
  bit   e_done [MAXC];
  bit   e_match[MAXC];
  bit   e_to   [MAXC];
  int   e_cnt  [MAXC];

  code_entry_if #(.DIGITS(DIGITS)) bus ();

  code_entry #(
    .DIGITS(DIGITS),
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled mid-cycle; cyc equals the index of the edge that produced the value.
  always @(negedge clk) begin
    if (bus.digit_strobe === 1'b1) begin n_strobe++; last_strobe_cyc = cyc; end
    if (bus.entry_done === 1'b1) begin n_done++; last_done_cyc = cyc; last_match = bus.code_match; end
    if (bus.timeout === 1'b1) begin n_to++; last_to_cyc = cyc; end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int code, input int hold, input int gap);
    bus.key_code  = 4'(code);
    bus.key_valid = 1'b1;
    idle(hold);
    bus.key_valid = 1'b0;
    idle(gap);
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.clear     = 1'b0;
    bus.secret    = 16'h1234;
    idle(3);
    total++; if (bus.digit_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", bus.digit_strobe); end
    total++; if (bus.digit_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.digit_count); end
    total++; if (bus.entry_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.entry_done); end
    total++; if (bus.code_match !== 1'b0) begin bad++; $display("FAIL reset_match: got %b want 0", bus.code_match); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_clean_entry();
    int s0, d0;
    bus.secret = 16'h1234;
    s0 = n_strobe; d0 = n_done;
    press_key(1, 6, 6);
    press_key(2, 6, 6);
    press_key(3, 6, 6);
    total++; if (bus.digit_count !== 4'd3) begin bad++; $display("FAIL clean_count3: got %0d want 3", bus.digit_count); end
    press_key(4, 6, 6);
    total++; if (n_strobe - s0 !== 4) begin bad++; $display("FAIL clean_strobes: got %0d want 4", n_strobe - s0); end
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL clean_done: got %0d want 1", n_done - d0); end
    total++; if (last_done_cyc !== last_strobe_cyc + 1) begin bad++; $display("FAIL clean_done_lat: got %0d want %0d", last_done_cyc, last_strobe_cyc + 1); end
    total++; if (last_match !== 1'b1) begin bad++; $display("FAIL clean_match: got %b want 1", last_match); end
    total++; if (bus.digit_count !== 4'd0) begin bad++; $display("FAIL clean_count0: got %0d want 0", bus.digit_count); end
  endtask

  task automatic test_wrong_code();
    int d0;
    d0 = n_done;
    press_key(1, 6, 6);
    press_key(2, 6, 6);
    press_key(3, 6, 6);
    press_key(5, 6, 6);
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL wrong_done: got %0d want 1", n_done - d0); end
    total++; if (last_match !== 1'b0) begin bad++; $display("FAIL wrong_match: got %b want 0", last_match); end
    total++; if (bus.digit_count !== 4'd0) begin bad++; $display("FAIL wrong_count: got %0d want 0", bus.digit_count); end
  endtask

  task automatic test_bounce();
    int pat[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    int s0, c0;
    s0 = n_strobe; c0 = cyc;
    bus.key_code = 4'd7;
    for (int i = 0; i < 9; i++) begin
      bus.key_valid = pat[i][0];
      idle(1);
    end
    total++; if (bus.digit_count !== 4'd1) begin bad++; $display("FAIL bounce_count: got %0d want 1", bus.digit_count); end
    bus.key_valid = 1'b1;
    idle(41);
    bus.key_valid = 1'b0;
    idle(8);
    total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL bounce_strobes: got %0d want 1", n_strobe - s0); end
    total++; if (last_strobe_cyc !== c0 + 9) begin bad++; $display("FAIL bounce_lat: got %0d want %0d", last_strobe_cyc, c0 + 9); end
  endtask

  task automatic test_cancel_clear();
    int s0, d0;
    s0 = n_strobe;
    press_key(1, 4, 4);
    press_key(2, 4, 4);
    total++; if (bus.digit_count !== 4'd2) begin bad++; $display("FAIL cancel_count2: got %0d want 2", bus.digit_count); end
    press_key(4'hA, 4, 4);
    total++; if (bus.digit_count !== 4'd2) begin bad++; $display("FAIL ignored_key: got %0d want 2", bus.digit_count); end
    press_key(4'hC, 4, 4);
    total++; if (bus.digit_count !== 4'd0) begin bad++; $display("FAIL cancel_count0: got %0d want 0", bus.digit_count); end
    total++; if (n_strobe - s0 !== 2) begin bad++; $display("FAIL cancel_strobes: got %0d want 2", n_strobe - s0); end
    press_key(9, 4, 4);
    total++; if (bus.digit_count !== 4'd1) begin bad++; $display("FAIL clear_count1: got %0d want 1", bus.digit_count); end
    s0 = n_strobe; d0 = n_done;
    bus.key_code  = 4'd8;
    bus.key_valid = 1'b1;
    idle(DB - 1);
    bus.clear = 1'b1;
    idle(1);
    bus.clear = 1'b0;
    idle(2);
    bus.key_valid = 1'b0;
    idle(6);
    total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL clear_strobe: got %0d want 0", n_strobe - s0); end
    total++; if (bus.digit_count !== 4'd0) begin bad++; $display("FAIL clear_count0: got %0d want 0", bus.digit_count); end
    total++; if (n_done - d0 !== 0) begin bad++; $display("FAIL clear_done: got %0d want 0", n_done - d0); end
  endtask

  task automatic test_timeout();
    int t0;
    t0 = n_to;
    press_key(3, 6, 10);
    total++; if (bus.digit_count !== 4'd1) begin bad++; $display("FAIL to_count1: got %0d want 1", bus.digit_count); end
    total++; if (n_to - t0 !== 0) begin bad++; $display("FAIL to_early: got %0d want 0", n_to - t0); end
    idle(30);
    total++; if (n_to - t0 !== 1) begin bad++; $display("FAIL to_pulse: got %0d want 1", n_to - t0); end
    total++; if (last_to_cyc - last_strobe_cyc !== int'(TO)) begin bad++; $display("FAIL to_lat: got %0d want %0d", last_to_cyc - last_strobe_cyc, TO); end
    total++; if (bus.digit_count !== 4'd0) begin bad++; $display("FAIL to_count0: got %0d want 0", bus.digit_count); end
    idle(60);
    total++; if (n_to - t0 !== 1) begin bad++; $display("FAIL to_idle0: got %0d want 1", n_to - t0); end
  endtask

  task automatic test_async_reset();
    int d0;
    press_key(1, 6, 6);
    bus.key_code  = 4'd2;
    bus.key_valid = 1'b1;
    idle(DB);
    total++; if (bus.digit_count !== 4'd2) begin bad++; $display("FAIL ar_count2: got %0d want 2", bus.digit_count); end
    total++; if (bus.digit_strobe !== 1'b1) begin bad++; $display("FAIL ar_strobe1: got %b want 1", bus.digit_strobe); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.digit_count !== 4'd0) begin bad++; $display("FAIL ar_count0: got %0d want 0", bus.digit_count); end
    total++; if (bus.digit_strobe !== 1'b0) begin bad++; $display("FAIL ar_strobe0: got %b want 0", bus.digit_strobe); end
    total++; if ({bus.entry_done, bus.code_match, bus.timeout} !== 3'b000) begin bad++; $display("FAIL ar_flags: got %b want 000", {bus.entry_done, bus.code_match, bus.timeout}); end
    bus.key_valid = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2);
    d0 = n_done;
    press_key(1, 6, 6);
    press_key(2, 6, 6);
    press_key(3, 6, 6);
    press_key(4, 6, 6);
    total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL ar_done: got %0d want 1", n_done - d0); end
    total++; if (last_match !== 1'b1) begin bad++; $display("FAIL ar_match: got %b want 1", last_match); end
  endtask

  task automatic test_random();
    int sec_d[4];
    logic [15:0] sec;
    int len, pos, last, val;
    bit pend;
    int q[$];
    sec = '0;
    for (int i = 0; i < 4; i++) begin
      sec_d[i] = int'($urandom_range(0, 9));
      sec = (sec << 4) | 16'(sec_d[i]);
    end
    for (int c = 0; c < MAXC; c++) begin
      kv_a[c]  = 1'b0;
      kc_a[c]  = int'($urandom_range(0, 15));
      acc_a[c] = -1;
    end
    // Clean presses: hold >= DB, gap >= DB, occasional gap long enough to time out.
    len = 2; pos = 0;
    for (int p = 0; p < 60; p++) begin
      int key, h, g, r;
      r = int'($urandom_range(0, 99));
      if (r < 10) begin key = 12; pos = 0; end
      else if (r < 55) begin key = sec_d[pos]; pos = (pos + 1) % 4; end
      else begin key = int'($urandom_range(0, 9)); pos = (pos + 1) % 4; end
      h = int'(DB) + int'($urandom_range(0, 4));
      g = ($urandom_range(0, 7) == 0) ? int'(TO) + int'($urandom_range(0, 5)) : int'(DB) + int'($urandom_range(0, 6));
      if (g >= int'(TO)) pos = 0;
      for (int k = 0; k < h; k++) begin
        kv_a[len + k] = 1'b1;
        kc_a[len + k] = key;
      end
      acc_a[len + int'(DB) - 1] = key;
      len += h + g;
    end
    len += 30;
    q.delete(); last = 0; pend = 1'b0;
    for (int c = 0; c < len; c++) begin
      e_str[c] = 1'b0; e_done[c] = 1'b0; e_match[c] = 1'b0; e_to[c] = 1'b0;
      if (pend) begin
        val = 0;
        foreach (q[i]) val = val * 16 + q[i];
        e_done[c]  = 1'b1;
        e_match[c] = (val == int'(sec));
        q.delete();
        pend = 1'b0;
      end else if (acc_a[c] >= 0 && acc_a[c] <= 9) begin
        q.push_back(acc_a[c]);
        e_str[c] = 1'b1;
        last = c;
        if (q.size() == int'(DIGITS)) pend = 1'b1;
      end else if (acc_a[c] == 12) begin
        q.delete();
        last = c;
      end else if (q.size() > 0 && c - last == int'(TO)) begin
        e_to[c] = 1'b1;
        q.delete();
      end
      e_cnt[c] = pend ? int'(DIGITS) - 1 : q.size();
    end
    bus.key_valid = 1'b0;
    bus.secret    = sec;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < len; c++) begin
      bus.key_valid = kv_a[c];
      bus.key_code  = 4'(kc_a[c]);
      @(posedge clk);
      @(negedge clk);
      total++; if (bus.digit_strobe !== e_str[c]) begin bad++; $display("FAIL rnd_strobe c=%0d: got %b want %b", c, bus.digit_strobe, e_str[c]); end
      total++; if (bus.digit_count !== 4'(e_cnt[c])) begin bad++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, bus.digit_count, e_cnt[c]); end
      total++; if (bus.entry_done !== e_done[c]) begin bad++; $display("FAIL rnd_done c=%0d: got %b want %b", c, bus.entry_done, e_done[c]); end
      total++; if (bus.code_match !== e_match[c]) begin bad++; $display("FAIL rnd_match c=%0d: got %b want %b", c, bus.code_match, e_match[c]); end
      total++; if (bus.timeout !== e_to[c]) begin bad++; $display("FAIL rnd_timeout c=%0d: got %b want %b", c, bus.timeout, e_to[c]); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_entry();
    test_wrong_code();
    test_bounce();
    test_cancel_clear();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
